// File: rtl/lcd_pkg.sv
// lcd_pkg: constants and types shared by the LCD page arbiter and its helpers.
//   LCD_CHARS       - characters on the 2x16 panel
//   LCD_PAGE_W      - bits in one full page (one ASCII byte per character)
//   LCD_BLANK_PAGE  - page of spaces shown after reset
//   lcd_arb_state_t - arbiter FSM state encoding
package lcd_pkg;

  localparam int LCD_CHARS  = 32;
  localparam int LCD_PAGE_W = 256;

  localparam logic [LCD_PAGE_W-1:0] LCD_BLANK_PAGE = {LCD_CHARS{8'h20}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LCD = 2'd1,
    LATCH    = 2'd2,
    HOLD     = 2'd3
  } lcd_arb_state_t;

endpackage

// File: rtl/lcd_page_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Searches req starting at last+1, wrapping to 0, and returns the first set bit.
// The entry at index 'last' is considered only after every other one.
// Ports:
//   req   [N-1:0]    in  - request vector
//   last  [IDXW-1:0] in  - index granted most recently
//   valid            out - at least one request is set
//   idx   [IDXW-1:0] out - chosen index (0 when valid is low)
module rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic            valid,
  output logic [IDXW-1:0] idx
);

  // Walk the candidates farthest-first so the nearest one after 'last' wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last) + i) % N]) begin
        valid = 1'b1;
        idx   = IDXW'((int'(last) + i) % N);
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/lcd_page_arbiter.sv
// lcd_page_arbiter: shares the 2x16 LCD between NREQ page sources.
// A round-robin grant latches one requester's 256-bit page into strdata,
// pulses ack/refresh, then holds it for HOLD_CYCLES before re-arbitrating.
// Optional feature macro: LCD_ARB_URGENT_EN (requester 0 is urgent: it wins
// every arbitration while requesting and a rising req[0] aborts another
// owner's hold).
// Ports:
//   CCLK      in  - system clock, rising edge
//   reset     in  - asynchronous active-low reset
//   req       in  - per-requester level request [NREQ]
//   page_in   in  - requester i page on bits [256i+255:256i]
//   lcd_busy  in  - display path is writing the panel
//   strdata   out - currently shown page (registered)
//   ack       out - one-hot pulse when a requester's page is latched
//   owner     out - index of the last granted requester
//   refresh   out - one-cycle redraw strobe
module lcd_page_arbiter
  import lcd_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic                         CCLK,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*LCD_PAGE_W-1:0]   page_in,
  input  logic                         lcd_busy,
  output logic [LCD_PAGE_W-1:0]        strdata,
  output logic [NREQ-1:0]              ack,
  output logic [$clog2(NREQ)-1:0]      owner,
  output logic                         refresh
);

  localparam int IDXW = $clog2(NREQ);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(NREQ - 1);

  lcd_arb_state_t   state, state_nxt;
  logic [IDXW-1:0]  winner, winner_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             do_latch;
  logic             pick_valid;
  logic [IDXW-1:0]  pick_idx;

`ifdef LCD_ARB_URGENT_EN
  logic             req0_d;
`endif

  // owner is the round-robin pointer: the previous grant is searched last.
  rr_pick #(
    .N    (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req   (req),
    .last  (owner),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state, winner selection and hold counter.
  always_comb begin
    state_nxt  = state;
    winner_nxt = winner;
    cnt_nxt    = cnt;
    do_latch   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          winner_nxt = pick_idx;
`ifdef LCD_ARB_URGENT_EN
          if (req[0]) begin
            winner_nxt = '0;
          end else begin
            winner_nxt = pick_idx;
          end
`endif
          state_nxt = lcd_busy ? WAIT_LCD : LATCH;
        end else begin
          state_nxt = IDLE;
        end
      end
      // Winner is frozen; only the panel becoming free moves us on.
      WAIT_LCD: begin
        if (!lcd_busy) begin
          state_nxt = LATCH;
        end else begin
          state_nxt = WAIT_LCD;
        end
      end
      LATCH: begin
        do_latch  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`ifdef LCD_ARB_URGENT_EN
        // Rising urgent request cuts another owner's hold short.
        if (req[0] && !req0_d && (owner != '0)) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = state_nxt;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FSM, winner and hold-counter registers.
  always_ff @(posedge CCLK or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      winner <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      winner <= winner_nxt;
      cnt    <= cnt_nxt;
    end
  end

`ifdef LCD_ARB_URGENT_EN
  // Previous req[0] level for rising-edge detection.
  always_ff @(posedge CCLK or negedge reset) begin
    if (!reset) begin
      req0_d <= 1'b0;
    end else begin
      req0_d <= req[0];
    end
  end
`endif

  // Registered outputs: page, owner and the ack/refresh pulses on a latch.
  always_ff @(posedge CCLK or negedge reset) begin
    if (!reset) begin
      strdata <= LCD_BLANK_PAGE;
      owner   <= LAST_IDX;
      ack     <= '0;
      refresh <= 1'b0;
    end else if (do_latch) begin
      strdata <= page_in[int'(winner)*LCD_PAGE_W +: LCD_PAGE_W];
      owner   <= winner;
      ack     <= NREQ'(1) << winner;
      refresh <= 1'b1;
    end else begin
      ack     <= '0;
      refresh <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_page_arbiter.sv
// Self-checking bench for lcd_page_arbiter (NREQ=4, HOLD_CYCLES=8).
// A timer-based model predicts every output each cycle; directed sections
// pin reset values, single grant, rotation order/spacing and busy stall.
module tb_lcd_page_arbiter;

  localparam int NREQ = 4;
  localparam int HOLD = 8;
  localparam int PW   = 256;

  logic                 CCLK;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*PW-1:0]   page_in;
  logic                 lcd_busy;
  logic [PW-1:0]        strdata;
  logic [NREQ-1:0]      ack;
  logic [1:0]           owner;
  logic                 refresh;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  lcd_page_arbiter #(
    .NREQ        (NREQ),
    .HOLD_CYCLES (HOLD),
    .CNT_W       (4)
  ) dut (
    .CCLK     (CCLK),
    .reset    (reset),
    .req      (req),
    .page_in  (page_in),
    .lcd_busy (lcd_busy),
    .strdata  (strdata),
    .ack      (ack),
    .owner    (owner),
    .refresh  (refresh)
  );

  initial CCLK = 1'b0;
  always #5 CCLK = ~CCLK;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [PW-1:0]   exp_strdata;
  logic [NREQ-1:0] exp_ack;
  logic [1:0]      exp_owner;
  logic            exp_refresh;
  bit              m_have;     // a winner has been chosen, not yet shown
  bit              m_latch;    // the next edge shows the winner's page
  int              m_winner;
  int              m_hold;     // edges of display time still to run
  bit              m_prev0;

  function automatic int rr_next(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return 0;
  endfunction

  always @(posedge CCLK or negedge reset) begin
    if (!reset) begin
      exp_strdata = {32{8'h20}};
      exp_ack     = '0;
      exp_owner   = 2'd3;
      exp_refresh = 1'b0;
      m_have = 0; m_latch = 0; m_winner = 0; m_hold = 0; m_prev0 = 0;
    end else begin
      exp_ack     = '0;
      exp_refresh = 1'b0;
      if (m_latch) begin
        exp_strdata = page_in[m_winner*PW +: PW];
        exp_owner   = 2'(m_winner);
        exp_ack[m_winner] = 1'b1;
        exp_refresh = 1'b1;
        m_latch = 0;
        m_have  = 0;
        m_hold  = HOLD;
      end else if (m_hold > 0) begin
        m_hold = m_hold - 1;
`ifdef LCD_ARB_URGENT_EN
        if (req[0] && !m_prev0 && exp_owner != 2'd0) m_hold = 0;
`endif
      end else if (m_have) begin
        if (!lcd_busy) m_latch = 1;
      end else if (req != '0) begin
        m_winner = rr_next(req, int'(exp_owner));
`ifdef LCD_ARB_URGENT_EN
        if (req[0]) m_winner = 0;
`endif
        m_have  = 1;
        m_latch = !lcd_busy;
      end
      m_prev0 = req[0];
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge CCLK) begin
    if (cmp_en) begin
      check("strdata", strdata, exp_strdata);
      check("ack", {252'b0, ack}, {252'b0, exp_ack});
      check("owner", {254'b0, owner}, {254'b0, exp_owner});
      check("refresh", {255'b0, refresh}, {255'b0, exp_refresh});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge CCLK);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '0;
    lcd_busy = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  function automatic logic [PW-1:0] make_page(input string s);
    logic [PW-1:0] p;
    p = {32{8'h20}};
    for (int i = 0; i < s.len() && i < 32; i++) p[8*i +: 8] = s[i];
    return p;
  endfunction

  initial begin
    int t_ref [5];
    int o_ref [5];
    int nref;
    int exp_seq [5];
    bit seen;
    logic [PW-1:0] pg2;
    exp_seq = '{0, 1, 2, 3, 0};

    reset = 1'b0;
    req = '0;
    lcd_busy = 1'b0;
    for (int j = 0; j < NREQ*PW/32; j++) page_in[32*j +: 32] = $urandom();
    tick();
    cmp_en = 1'b1;

    // Reset values
    check("reset_strdata", strdata, {32{8'h20}});
    check("reset_owner", {254'b0, owner}, 256'd3);
    check("reset_ack", {252'b0, ack}, 256'd0);
    check("reset_refresh", {255'b0, refresh}, 256'd0);
    tick();
    reset = 1'b1;

    // Single requester: slot 2
    pg2 = make_page("SLOT2 PAGE");
    page_in[2*PW +: PW] = pg2;
    req = 4'b0100;
    tick();
    tick();
    check("single_ack", {252'b0, ack}, 256'h4);
    check("single_refresh", {255'b0, refresh}, 256'd1);
    check("single_owner", {254'b0, owner}, 256'd2);
    check("single_strdata", strdata, pg2);
    req = '0;
    tick();
    check("single_refresh_pulse", {255'b0, refresh}, 256'd0);
    tick();

    // Rotation: reset mid-hold, then all four requesting
    do_reset();
    req = 4'b1111;
    nref = 0;
    for (int c = 0; c < 80 && nref < 5; c++) begin
      tick();
      if (refresh) begin
        t_ref[nref] = c;
        o_ref[nref] = int'(owner);
        nref++;
      end
    end
    n_cmp++;
    if (nref != 5) begin
      n_bad++;
      $display("FAIL rotation_timeout: got %0d refreshes expected 5", nref);
    end else begin
      for (int i = 0; i < 5; i++) begin
        check("rotation_owner", 256'(o_ref[i]), 256'(exp_seq[i]));
        if (i > 0) check("rotation_spacing", 256'(t_ref[i] - t_ref[i-1]), 256'd10);
      end
    end

    // Busy stall
    do_reset();
    req = 4'b0010;
    lcd_busy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("busy_no_ack", {252'b0, ack}, 256'd0);
    end
    lcd_busy = 1'b0;
    tick();
    check("busy_release_wait", {252'b0, ack}, 256'd0);
    tick();
    check("busy_ack1", {252'b0, ack}, 256'h2);
    req = '0;

`ifdef LCD_ARB_URGENT_EN
    // Urgent: requester 0 aborts slot 2's hold
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    tick();
    tick();
    tick();
    req = 4'b0101;
    seen = 1'b0;
    for (int c = 0; c < 3 && !seen; c++) begin
      tick();
      if (ack == 4'b0001) seen = 1'b1;
    end
    check("urgent_ack0", {255'b0, seen}, 256'd1);
    check("urgent_strdata", strdata, page_in[0 +: PW]);
    req = '0;
`endif

    // Randomized traffic checked by the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) lcd_busy = ~lcd_busy;
      for (int j = 0; j < NREQ*PW/32; j++) page_in[32*j +: 32] = $urandom();
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      tick();
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_page_arbiter.md
# lcd_page_arbiter

Shares the 2×16-character LCD between several requesters, each offering a full 256-bit page (32 ASCII bytes). A round-robin scheduler grants one page at a time and holds it for a minimum display time. It drives the `strdata` bus and a refresh strobe into the display path. It sits between the system's status/debug sources and the `display` block.

## Interface

Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `HOLD_CYCLES`, 50_000_000: minimum cycles a granted page stays shown, about 1 s at 50 MHz.
- `CNT_W`, 26: hold counter width; must satisfy `2^CNT_W > HOLD_CYCLES`.

Ports:
- `CCLK`, in, 1: single system clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `req`, in, NREQ: per-requester level request; held high while the requester wants the screen.
- `page_in`, in, NREQ×256: requester *i* page on bits [256i+255 : 256i]; byte 0 is in bits [7:0] and is the top-left character.
- `lcd_busy`, in, 1: high while the downstream display path is writing the panel.
- `strdata`, out, 256: currently shown page, registered.
- `ack`, out, NREQ: one-hot, one-cycle pulse when requester *i*'s page is latched.
- `owner`, out, clog2(NREQ): index of the last granted requester.
- `refresh`, out, 1: one-cycle pulse that tells the display path to redraw `strdata`.

## Operation

States: `IDLE`, `WAIT_LCD`, `LATCH`, `HOLD`.

- **IDLE**
  - If any `req` bit is set, pick a winner by round robin, starting at `owner+1` and wrapping to 0.
  - If `lcd_busy` is high, go to `WAIT_LCD`; otherwise go to `LATCH`.
- **WAIT_LCD**
  - Stay while `lcd_busy` is high; then go to `LATCH`.
  - The winner is frozen here; later requests do not re-arbitrate.
- **LATCH** (one cycle)
  - `strdata` ← winner's `page_in` slice; `owner` ← winner.
  - Pulse `ack[winner]` and `refresh`.
  - Clear the hold counter and go to `HOLD`.
- **HOLD**
  - The counter increments every cycle.
  - When it reaches `HOLD_CYCLES-1`, go to `IDLE`.
- **Re-arbitration after HOLD**
  - The current owner is eligible again only if no other request is pending; in that case its page is re-latched, which refreshes its content.
  - If no requests are pending, `strdata` keeps its value and no `refresh` is issued.
- **Request withdrawal**
  - If the winner's `req` drops while in `WAIT_LCD`, the grant still completes and the latched data is whatever `page_in` holds at `LATCH`.
- **Round-robin pointer**
  - `owner` is the only round-robin state.
  - Only a completed `LATCH` advances it.

## Timing

- Reset (async assert, sync release) sets:
  - `strdata` = 32 × 8'h20 (blank page).
  - `ack` = 0, `refresh` = 0, `owner` = NREQ-1, so requester 0 wins first.
  - State = `IDLE`, counter = 0.
- Latency: `req` sampled high in `IDLE` at edge *k* with `lcd_busy` low → `ack`, `refresh` and the new `strdata` are visible after edge *k+1*.
- Minimum spacing between two `refresh` pulses: `HOLD_CYCLES + 2` cycles.
- `lcd_busy` rising in the same cycle as the grant decision → go to `WAIT_LCD`; no `refresh` is issued while busy.
- Reset mid-`HOLD`/`WAIT_LCD` → immediate return to reset values; no partial `ack`.
- Counter wrap cannot occur, because of the `CNT_W` constraint on `HOLD_CYCLES`.

## Configuration

Macro: `LCD_ARB_URGENT_EN`.

- **Defined:** requester 0 is urgent.
  - If `req[0]` rises while in `HOLD` and owner ≠ 0, the hold is aborted and requester 0 wins the next arbitration outright.
  - While `req[0]` is high, requester 0 also wins every `IDLE` decision regardless of round robin.
- **Undefined:** pure round robin; `HOLD` is never cut short.

## Structure

- Package `lcd_pkg` holds:
  - `LCD_CHARS` = 32.
  - `LCD_PAGE_W` = 256.
  - `LCD_BLANK_PAGE` = {32{8'h20}}.
  - The state enum type `lcd_arb_state_t`.
- Sub-module `rr_pick` is a combinational round-robin picker:
  - Inputs: `req`, `last`.
  - Outputs: `valid`, `idx`.
  - It is reused by other shared-resource blocks.

## Test plan

Benches use `HOLD_CYCLES` = 8.

- **Reset:** `reset`=0 → `strdata`=all 8'h20, `owner`=NREQ-1, `ack`=0, `refresh`=0.
- **Single requester:** `req`=4'b0100 with `page_in[2]`="SLOT2…" → after one edge, `ack`=4'b0100, `refresh`=1 for one cycle, `strdata`=slot-2 page, `owner`=2.
- **Rotation:** `req`=4'b1111 held → grants in order 0,1,2,3,0, with `refresh` pulses exactly 10 cycles apart.
- **Busy stall:** `lcd_busy`=1 for 5 cycles while `req[1]`=1 → no `ack` during busy; `ack[1]` appears one cycle after `lcd_busy` falls.
- **Urgent:** with `LCD_ARB_URGENT_EN`, owner=2 at hold count 3, `req[0]` rises → `ack[0]` within 3 cycles, and `strdata` = page 0.
